// File: rtl/cache_set_nway.sv
// One N-way set-associative cache set: write-back, write-allocate, true-LRU ages,
// a single-line memory port for writeback and fill.
module cache_set_nway #(
   parameter  int unsigned WAYS   = 8,
   parameter  int unsigned TAG_W  = 24,
   parameter  int unsigned OFF_W  = 6,
   localparam int unsigned LINE_W = 8 * (2 ** OFF_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [TAG_W-1:0]  req_tag,
   input  logic [OFF_W-1:0]  req_offset,
   input  logic [1:0]        req_size,
   input  logic [63:0]       req_wdata,
   output logic              resp_valid,
   output logic [63:0]       resp_rdata,
   output logic              resp_hit,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_we,
   output logic [TAG_W-1:0]  mem_req_tag,
   output logic [LINE_W-1:0] mem_wline,
   input  logic              mem_resp_valid,
   input  logic [LINE_W-1:0] mem_rline
);
   localparam int unsigned WAY_W = $clog2(WAYS);

   typedef enum logic [2:0] {StIdle, StLookup, StWb, StFill, StResp} state_e;

   state_e            state_q, state_d;
   logic [WAYS-1:0]   way_valid_q, way_dirty_q;
   logic [TAG_W-1:0]  way_tag_q  [WAYS];
   logic [LINE_W-1:0] way_line_q [WAYS];
   logic [WAY_W-1:0]  way_age_q  [WAYS];

   logic [1:0]        rq_op_q, rq_op_d;
   logic [TAG_W-1:0]  rq_tag_q, rq_tag_d;
   logic [OFF_W-1:0]  rq_off_q, rq_off_d;
   logic [1:0]        rq_size_q, rq_size_d;
   logic [63:0]       rq_wdata_q, rq_wdata_d;
   logic [WAY_W-1:0]  way_q, way_d;
   logic              fill_sent_q, fill_sent_d;
   logic [63:0]       rdata_q, rdata_d;
   logic              hit_q, hit_d;

   logic              hit;
   logic [WAY_W-1:0]  hit_way, vic_way, acc_way;
   logic              acc_fill, acc_en;
   logic [LINE_W-1:0] acc_line;
   logic [63:0]       acc_rdata;
   logic [OFF_W-1:0]  eff_off;

   // Tag match picks the lowest matching way; victim is lowest invalid, else oldest.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      vic_way = '0;
      for (int w = int'(WAYS) - 1; w >= 0; w--) begin
         if (way_valid_q[w] && (way_tag_q[w] == rq_tag_q)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
      for (int w = 0; w < int'(WAYS); w++) begin
         if (way_age_q[w] == WAY_W'(WAYS - 1)) vic_way = WAY_W'(w);
      end
      for (int w = int'(WAYS) - 1; w >= 0; w--) begin
         if (!way_valid_q[w]) vic_way = WAY_W'(w);
      end
   end

   // Access datapath shared by the hit path and the fill-completion path.
   always_comb begin
      acc_fill  = (state_q == StFill) && fill_sent_q && mem_resp_valid;
      acc_en    = acc_fill || ((state_q == StLookup) && hit);
      acc_way   = acc_fill ? way_q : hit_way;
      acc_line  = acc_fill ? mem_rline : way_line_q[hit_way];
      acc_rdata = '0;
      eff_off   = (rq_off_q >> rq_size_q) << rq_size_q;
      for (int i = 0; i < 8; i++) begin
         if (i < (1 << rq_size_q)) begin
            if (rq_op_q == 2'd1) begin
               acc_line[(int'(eff_off) + i) * 8 +: 8] = rq_wdata_q[i * 8 +: 8];
            end else begin
               acc_rdata[i * 8 +: 8] = acc_line[(int'(eff_off) + i) * 8 +: 8];
            end
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rq_op_d     = rq_op_q;
      rq_tag_d    = rq_tag_q;
      rq_off_d    = rq_off_q;
      rq_size_d   = rq_size_q;
      rq_wdata_d  = rq_wdata_q;
      way_d       = way_q;
      fill_sent_d = fill_sent_q;
      rdata_d     = rdata_q;
      hit_d       = hit_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               rq_op_d    = req_op;
               rq_tag_d   = req_tag;
               rq_off_d   = req_offset;
               rq_size_d  = req_size;
               rq_wdata_d = req_wdata;
               if (req_op[1]) begin
                  state_d = StResp;
                  rdata_d = '0;
                  hit_d   = 1'b1;
               end else begin
                  state_d = StLookup;
               end
            end
         end
         StLookup: begin
            if (hit) begin
               state_d = StResp;
               rdata_d = acc_rdata;
               hit_d   = 1'b1;
            end else begin
               way_d       = vic_way;
               fill_sent_d = 1'b0;
               state_d     = (way_valid_q[vic_way] && way_dirty_q[vic_way]) ? StWb : StFill;
            end
         end
         StWb: begin
            if (mem_req_ready) begin
               state_d     = StFill;
               fill_sent_d = 1'b0;
            end
         end
         StFill: begin
            if (!fill_sent_q) begin
               if (mem_req_ready) fill_sent_d = 1'b1;
            end else if (mem_resp_valid) begin
               state_d = StResp;
               rdata_d = acc_rdata;
               hit_d   = 1'b0;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         rq_op_q     <= '0;
         rq_tag_q    <= '0;
         rq_off_q    <= '0;
         rq_size_q   <= '0;
         rq_wdata_q  <= '0;
         way_q       <= '0;
         fill_sent_q <= 1'b0;
         rdata_q     <= '0;
         hit_q       <= 1'b0;
         way_valid_q <= '0;
         way_dirty_q <= '0;
         for (int w = 0; w < int'(WAYS); w++) way_age_q[w] <= WAY_W'(w);
      end else begin
         state_q     <= state_d;
         rq_op_q     <= rq_op_d;
         rq_tag_q    <= rq_tag_d;
         rq_off_q    <= rq_off_d;
         rq_size_q   <= rq_size_d;
         rq_wdata_q  <= rq_wdata_d;
         way_q       <= way_d;
         fill_sent_q <= fill_sent_d;
         rdata_q     <= rdata_d;
         hit_q       <= hit_d;
         if (acc_en) begin
            way_valid_q[acc_way] <= 1'b1;
            if (rq_op_q == 2'd1) begin
               way_dirty_q[acc_way] <= 1'b1;
            end else if (acc_fill) begin
               way_dirty_q[acc_way] <= 1'b0;
            end
            for (int w = 0; w < int'(WAYS); w++) begin
               if (WAY_W'(w) == acc_way) begin
                  way_age_q[w] <= '0;
               end else if (way_age_q[w] < way_age_q[acc_way]) begin
                  way_age_q[w] <= way_age_q[w] + 1'b1;
               end
            end
         end
      end
   end

   // Line and tag storage need no reset; validity is tracked separately.
   always_ff @(posedge clk) begin
      if (acc_en) begin
         way_tag_q[acc_way]  <= rq_tag_q;
         way_line_q[acc_way] <= acc_line;
      end
   end

   always_comb begin
      req_ready     = (state_q == StIdle);
      resp_valid    = (state_q == StResp);
      resp_rdata    = rdata_q;
      resp_hit      = hit_q;
      mem_req_valid = (state_q == StWb) || ((state_q == StFill) && !fill_sent_q);
      mem_req_we    = (state_q == StWb);
      mem_req_tag   = mem_req_we ? way_tag_q[way_q] : rq_tag_q;
      mem_wline     = mem_req_we ? way_line_q[way_q] : '0;
   end

endmodule
